// File: rtl/issue_queue_ooo_if.sv
// Dispatch, writeback-broadcast, FU-ready and issue bundle of the out-of-order issue queue.
// The testbench or upstream logic drives through master; the queue attaches through slave.
interface issue_queue_ooo_if #(
  parameter int RS_SIZE  = 16,
  parameter int PR_SIZE  = 7,
  parameter int ROB_SIZE = 6,
  parameter int FU_SIZE  = 2,
  parameter int FU_ARRAY = 3,
  parameter int ISSUE_W  = 2,
  parameter int WB_W     = 2
);
  logic                          flush;
  logic                          disp_valid;
  logic                          disp_ready;
  logic [3:0]                    disp_op;
  logic [PR_SIZE-1:0]            disp_rd;
  logic [PR_SIZE-1:0]            disp_rs1;
  logic [PR_SIZE-1:0]            disp_rs2;
  logic                          disp_rs1_rdy;
  logic                          disp_rs2_rdy;
  logic [31:0]                   disp_rs1_val;
  logic [31:0]                   disp_rs2_val;
  logic [31:0]                   disp_imm;
  logic [FU_SIZE-1:0]            disp_fu;
  logic [ROB_SIZE-1:0]           disp_rob;
  logic [WB_W-1:0]               wb_valid;
  logic [WB_W*PR_SIZE-1:0]       wb_tag;
  logic [WB_W*32-1:0]            wb_data;
  logic [FU_ARRAY-1:0]           fu_ready_in;
  logic [ISSUE_W-1:0]            iss_valid;
  logic [ISSUE_W*4-1:0]          iss_op;
  logic [ISSUE_W*PR_SIZE-1:0]    iss_rd;
  logic [ISSUE_W*32-1:0]         iss_rs1_val;
  logic [ISSUE_W*32-1:0]         iss_rs2_val;
  logic [ISSUE_W*32-1:0]         iss_imm;
  logic [ISSUE_W*FU_SIZE-1:0]    iss_fu;
  logic [ISSUE_W*ROB_SIZE-1:0]   iss_rob;
  logic [$clog2(RS_SIZE+1)-1:0]  count;

  modport master (
    output flush, disp_valid, disp_op, disp_rd, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_val, disp_rs2_val, disp_imm, disp_fu, disp_rob, wb_valid, wb_tag, wb_data,
           fu_ready_in,
    input  disp_ready, iss_valid, iss_op, iss_rd, iss_rs1_val, iss_rs2_val, iss_imm, iss_fu,
           iss_rob, count
  );

  modport slave (
    input  flush, disp_valid, disp_op, disp_rd, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
           disp_rs1_val, disp_rs2_val, disp_imm, disp_fu, disp_rob, wb_valid, wb_tag, wb_data,
           fu_ready_in,
    output disp_ready, iss_valid, iss_op, iss_rd, iss_rs1_val, iss_rs2_val, iss_imm, iss_fu,
           iss_rob, count
  );
endinterface

// File: rtl/issue_queue_ooo.sv
// Unified OoO issue queue: wakes sources from WB_W broadcasts, issues up to ISSUE_W oldest-ready
// entries per cycle (one per FU) through registered iss_* outputs; disp_ready drops when full.
module issue_queue_ooo #(
  parameter int RS_SIZE  = 16,
  parameter int PR_SIZE  = 7,
  parameter int ROB_SIZE = 6,
  parameter int FU_SIZE  = 2,
  parameter int FU_ARRAY = 3,
  parameter int ISSUE_W  = 2,
  parameter int WB_W     = 2
) (
  input logic              clk,
  input logic              rst,
  issue_queue_ooo_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);
  localparam int FU_N  = 1 << FU_SIZE;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_SIZE);

  typedef struct packed {
    logic [3:0]          op;
    logic [PR_SIZE-1:0]  rd;
    logic [PR_SIZE-1:0]  rs1;
    logic [PR_SIZE-1:0]  rs2;
    logic                rs1_rdy;
    logic                rs2_rdy;
    logic [31:0]         rs1_val;
    logic [31:0]         rs2_val;
    logic [31:0]         imm;
    logic [FU_SIZE-1:0]  fu;
    logic [ROB_SIZE-1:0] rob;
  } entry_t;

  typedef struct packed {
    logic [3:0]          op;
    logic [PR_SIZE-1:0]  rd;
    logic [31:0]         rs1_val;
    logic [31:0]         rs2_val;
    logic [31:0]         imm;
    logic [FU_SIZE-1:0]  fu;
    logic [ROB_SIZE-1:0] rob;
  } iss_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] valid_q, valid_d;
  // older_q[j][i] set means entry j was dispatched before entry i
  logic [RS_SIZE-1:0] older_q [RS_SIZE];
  logic [RS_SIZE-1:0] older_d [RS_SIZE];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ISSUE_W-1:0] iss_vld_q, iss_vld_d;
  iss_t               iss_q [ISSUE_W];
  iss_t               iss_d [ISSUE_W];

  logic [FU_N-1:0]    fu_rdy;
  logic [RS_SIZE-1:0] elig;
  logic [ISSUE_W-1:0] sel_vld;
  logic [IDX_W-1:0]   sel_idx [ISSUE_W];
  logic [RS_SIZE-1:0] taken, cand;
  logic [FU_N-1:0]    claimed;
  logic               oldest;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_fire;
  entry_t             new_ent;
  logic [CNT_W-1:0]   n_iss;

  always_comb begin
    fu_rdy = '0;
    fu_rdy[FU_ARRAY-1:0] = bus.fu_ready_in;
    for (int i = 0; i < RS_SIZE; i++) begin
      elig[i] = valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy && fu_rdy[ent_q[i].fu];
    end
  end

  // Each slot picks the oldest candidate left after earlier slots removed their entry and FU.
  always_comb begin
    taken   = '0;
    claimed = '0;
    cand    = '0;
    oldest  = 1'b0;
    sel_vld = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      sel_idx[k] = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        cand[i] = elig[i] && !taken[i] && !claimed[ent_q[i].fu];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        oldest = cand[i];
        for (int j = 0; j < RS_SIZE; j++) begin
          if (cand[j] && older_q[j][i]) oldest = 1'b0;
        end
        if (oldest) begin
          sel_vld[k] = 1'b1;
          sel_idx[k] = IDX_W'(i);
        end
      end
      if (sel_vld[k]) begin
        taken[sel_idx[k]]            = 1'b1;
        claimed[ent_q[sel_idx[k]].fu] = 1'b1;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign bus.disp_ready = !rst && (count_q < FULL);
  assign disp_fire      = bus.disp_valid && bus.disp_ready && !bus.flush;

  always_comb begin
    ent_d     = ent_q;
    valid_d   = valid_q;
    older_d   = older_q;
    iss_d     = iss_q;
    iss_vld_d = sel_vld;
    n_iss     = '0;

    for (int k = 0; k < ISSUE_W; k++) begin
      if (sel_vld[k]) begin
        valid_d[sel_idx[k]] = 1'b0;
        iss_d[k].op         = ent_q[sel_idx[k]].op;
        iss_d[k].rd         = ent_q[sel_idx[k]].rd;
        iss_d[k].rs1_val    = ent_q[sel_idx[k]].rs1_val;
        iss_d[k].rs2_val    = ent_q[sel_idx[k]].rs2_val;
        iss_d[k].imm        = ent_q[sel_idx[k]].imm;
        iss_d[k].fu         = ent_q[sel_idx[k]].fu;
        iss_d[k].rob        = ent_q[sel_idx[k]].rob;
        n_iss               = n_iss + CNT_W'(1);
      end
    end

    // Ports scanned high to low so the lowest matching port is the last writer.
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int p = WB_W - 1; p >= 0; p--) begin
        if (bus.wb_valid[p] && !ent_q[i].rs1_rdy &&
            bus.wb_tag[p*PR_SIZE +: PR_SIZE] == ent_q[i].rs1) begin
          ent_d[i].rs1_rdy = 1'b1;
          ent_d[i].rs1_val = bus.wb_data[p*32 +: 32];
        end
        if (bus.wb_valid[p] && !ent_q[i].rs2_rdy &&
            bus.wb_tag[p*PR_SIZE +: PR_SIZE] == ent_q[i].rs2) begin
          ent_d[i].rs2_rdy = 1'b1;
          ent_d[i].rs2_val = bus.wb_data[p*32 +: 32];
        end
      end
    end

    new_ent.op      = bus.disp_op;
    new_ent.rd      = bus.disp_rd;
    new_ent.rs1     = bus.disp_rs1;
    new_ent.rs2     = bus.disp_rs2;
    new_ent.rs1_rdy = bus.disp_rs1_rdy;
    new_ent.rs2_rdy = bus.disp_rs2_rdy;
    new_ent.rs1_val = bus.disp_rs1_val;
    new_ent.rs2_val = bus.disp_rs2_val;
    new_ent.imm     = bus.disp_imm;
    new_ent.fu      = bus.disp_fu;
    new_ent.rob     = bus.disp_rob;
    for (int p = WB_W - 1; p >= 0; p--) begin
      if (bus.wb_valid[p] && !bus.disp_rs1_rdy && bus.wb_tag[p*PR_SIZE +: PR_SIZE] == bus.disp_rs1) begin
        new_ent.rs1_rdy = 1'b1;
        new_ent.rs1_val = bus.wb_data[p*32 +: 32];
      end
      if (bus.wb_valid[p] && !bus.disp_rs2_rdy && bus.wb_tag[p*PR_SIZE +: PR_SIZE] == bus.disp_rs2) begin
        new_ent.rs2_rdy = 1'b1;
        new_ent.rs2_val = bus.wb_data[p*32 +: 32];
      end
    end

    if (disp_fire) begin
      ent_d[free_idx]   = new_ent;
      valid_d[free_idx] = 1'b1;
      for (int j = 0; j < RS_SIZE; j++) begin
        older_d[free_idx][j] = 1'b0;
        older_d[j][free_idx] = valid_q[j];
      end
    end

    count_d = count_q + CNT_W'(disp_fire) - n_iss;

    if (bus.flush) begin
      valid_d   = '0;
      count_d   = '0;
      iss_vld_d = '0;
      iss_d     = iss_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      count_q   <= '0;
      iss_vld_q <= '0;
      for (int k = 0; k < ISSUE_W; k++) iss_q[k] <= '0;
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
      older_q   <= older_d;
      ent_q     <= ent_d;
    end
  end

  assign bus.iss_valid = iss_vld_q;
  assign bus.count     = count_q;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_iss
    assign bus.iss_op[k*4 +: 4]                  = iss_q[k].op;
    assign bus.iss_rd[k*PR_SIZE +: PR_SIZE]      = iss_q[k].rd;
    assign bus.iss_rs1_val[k*32 +: 32]           = iss_q[k].rs1_val;
    assign bus.iss_rs2_val[k*32 +: 32]           = iss_q[k].rs2_val;
    assign bus.iss_imm[k*32 +: 32]               = iss_q[k].imm;
    assign bus.iss_fu[k*FU_SIZE +: FU_SIZE]      = iss_q[k].fu;
    assign bus.iss_rob[k*ROB_SIZE +: ROB_SIZE]   = iss_q[k].rob;
  end
endmodule

// File: doc/issue_queue_ooo.md
Name: issue_queue_ooo

Overview:
- Parametrised successor to the unified issue queue in the RISC-V out-of-order core.
- Sits between rename/dispatch and the functional units (ALU0, ALU1, LSU).
- Holds up to RS_SIZE renamed instructions and wakes operands from WB_W writeback broadcast ports.
- Each cycle, selects up to ISSUE_W ready instructions, oldest first, to FUs that assert ready. Supports pipeline flush.

Parameters:
- RS_SIZE, 16, entry count (≥2).
- PR_SIZE, 7, physical register tag width.
- ROB_SIZE, 6, ROB index width.
- FU_SIZE, 2, FU index width.
- FU_ARRAY, 3, FU count (0 = ALU0, 1 = ALU1, 2 = LSU).
- ISSUE_W, 2, issue ports.
- WB_W, 2, wakeup/writeback ports.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept this cycle.
- disp_op  in  4  operation code (ADD=1 … SW=10).
- disp_rd  in  PR_SIZE  destination tag.
- disp_rs1 / disp_rs2  in  PR_SIZE  source tags.
- disp_rs1_rdy / disp_rs2_rdy  in  1  source value already valid.
- disp_rs1_val / disp_rs2_val  in  32  source values (meaningful when rdy).
- disp_imm  in  32  immediate.
- disp_fu  in  FU_SIZE  target FU.
- disp_rob  in  ROB_SIZE  ROB index.
- wb_valid  in  WB_W  writeback broadcast valid per port.
- wb_tag  in  WB_W*PR_SIZE  broadcast tags, port p at [p*PR_SIZE +: PR_SIZE].
- wb_data  in  WB_W*32  broadcast values.
- fu_ready_in  in  FU_ARRAY  FU i accepts an instruction this cycle.
- iss_valid  out  ISSUE_W  issue slot valid.
- iss_op  out  ISSUE_W*4  per slot.
- iss_rd  out  ISSUE_W*PR_SIZE.
- iss_rs1_val / iss_rs2_val  out  ISSUE_W*32.
- iss_imm  out  ISSUE_W*32.
- iss_fu  out  ISSUE_W*FU_SIZE.
- iss_rob  out  ISSUE_W*ROB_SIZE.
- count  out  $clog2(RS_SIZE+1)  occupied entries.

Behaviour:
- Reset (rst high at posedge): all entries invalid; count = 0; all iss_* outputs = 0; iss_valid = 0. disp_ready = 0 while rst is high.
- disp_ready = !rst && (count < RS_SIZE). Combinational from stored count; entries freed this cycle are not counted.
- Dispatch handshake: an entry is written at the posedge where disp_valid && disp_ready && !flush. It goes to the lowest-index free entry and records its age order.
  - disp_valid with disp_ready low: request is dropped, no state change. Upstream must hold it.
- Wakeup: at each posedge, any valid entry whose unready source tag equals wb_tag[p] with wb_valid[p] sets its ready bit and captures wb_data[p].
  - If several ports match one source, the lowest p wins.
  - A dispatching instruction is also compared against same-cycle wb broadcasts. On a match it is stored ready with the broadcast data (no lost wakeup).
- Eligible entry: valid, both sources ready, fu_ready_in[fu] = 1. Evaluated on state at the start of the cycle, so:
  - a newly dispatched entry is eligible no earlier than the cycle after it is written;
  - a just-woken entry is likewise eligible the following cycle.
- Select: slot 0 takes the oldest eligible entry. Slot k takes the oldest eligible entry not taken by slots <k whose FU is not claimed by slots <k. At most one issue per FU per cycle.
- Issue latency: the selected entry is freed and its fields are registered onto iss_* at the same posedge. iss_valid[k] is high for exactly one cycle per issue.
  - Unused slots drive iss_valid[k] = 0; their other fields hold their previous values.
- count next = count + dispatched − issued. Simultaneous dispatch and issue when full: dispatch is still blocked (disp_ready was 0).
- Age: strict dispatch order, preserved across frees and reuse of entry indices. An age matrix or equivalent is allowed.
- Flush at posedge: all entries invalid, count = 0, iss_valid = 0 next cycle, any same-cycle dispatch discarded. Flush overrides wakeup and issue.
- Reset or flush mid-operation: in-flight selections are cancelled, with no partial issue.
- Tag 0 is not special-cased. Rename must present x0 sources with rdy = 1.

Test Plan:
- Reset/basic issue: assert rst 2 cycles, then dispatch ADD rd=5 rs1=1 rs2=2, both rdy, vals 3/4, fu=0, fu_ready_in=3'b111 → count=1 after edge; next edge iss_valid=2'b01, iss_rs1_val=3, iss_rs2_val=4, iss_rd=5, count=0.
- Wakeup plus same-cycle bypass:
  - Dispatch rs1=9 unready. Next cycle wb_valid=01, wb_tag=9, wb_data=0xABCD → issues one cycle later with iss_rs1_val=0xABCD.
  - Repeat with the wb broadcast in the same cycle as dispatch → issues the following cycle with the same value.
- Oldest-first and FU conflict: dispatch ready A(fu0), B(fu0), C(fu1) in order → first issue cycle slots carry A and C; next cycle B.
- FU stall: dispatch ready LW fu=2 with fu_ready_in[2]=0 for 5 cycles → no issue, count=1; raise fu_ready_in[2] → iss_valid next edge with iss_fu=2.
- Full/back-pressure: fill 16 entries with unready sources → disp_ready=0 and count=16; a 17th request is not stored; one wakeup plus issue frees an entry → disp_ready=1 the cycle after the issue edge.
- Flush: with 8 entries valid, assert flush together with disp_valid and a matching wb → next cycle count=0, iss_valid=0; a later dispatch is accepted into entry 0.
